// File: rtl/prog_load_ctrl.sv
// Program-load and run/halt/step sequencer for one TIS node's instruction RAM.
// Optional PROG_LOAD_STEP_CNT_EN adds a saturating executed-cycle counter (step_count).
module prog_load_ctrl #(
  parameter int OPCODE_W    = 21,
  parameter int ADDR_W      = 5,
  parameter int MAX_ENTRIES = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [OPCODE_W-1:0] load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [OPCODE_W-1:0] mem_wdata,
  output logic [ADDR_W:0]     num_entries,
  output logic                node_reset,
  output logic                node_clk_en,
  input  logic                run_cmd,
  input  logic                halt_cmd,
  input  logic                step_cmd,
  output logic                running,
  output logic                load_err
`ifdef PROG_LOAD_STEP_CNT_EN
  ,
  output logic [15:0]         step_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HALTED, RUN, STEP} state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(MAX_ENTRIES - 1);

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic            start_load;
  logic            word_acc;

  // load_start outranks every other command in all states except LOAD and FLUSH
  always_comb begin
    start_load = 1'b0;
    if (load_start && state != LOAD && state != FLUSH)
      start_load = 1'b1;
  end

  always_comb begin
    word_acc = 1'b0;
    if (state == LOAD && load_valid && load_ready)
      word_acc = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      load_ready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      num_entries <= '0;
      node_reset  <= 1'b1;
      node_clk_en <= 1'b0;
      running     <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_load) begin
        state       <= LOAD;
        cnt         <= '0;
        load_ready  <= 1'b1;
        load_err    <= 1'b0;
        node_reset  <= 1'b1;
        node_clk_en <= 1'b0;
        running     <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (word_acc) begin
              mem_we    <= 1'b1;
              mem_addr  <= cnt[ADDR_W-1:0];
              mem_wdata <= load_data;
              cnt       <= cnt + 1'b1;
              // a full RAM without load_last closes the program as an overflow
              if (load_last || cnt == LAST_CNT) begin
                state      <= FLUSH;
                load_ready <= 1'b0;
                load_err   <= ~load_last;
              end
            end
          end
          FLUSH: begin
            num_entries <= cnt;
            node_reset  <= 1'b0;
            state       <= HALTED;
          end
          HALTED: begin
            if (halt_cmd) begin
              state <= HALTED;
            end else if (step_cmd) begin
              state       <= STEP;
              node_clk_en <= 1'b1;
            end else if (run_cmd) begin
              state       <= RUN;
              node_clk_en <= 1'b1;
              running     <= 1'b1;
            end
          end
          RUN: begin
            if (halt_cmd) begin
              state       <= HALTED;
              node_clk_en <= 1'b0;
              running     <= 1'b0;
            end
          end
          STEP: begin
            state       <= HALTED;
            node_clk_en <= 1'b0;
          end
          IDLE: begin
            node_reset <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PROG_LOAD_STEP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_load)
      step_count <= '0;
    else if (node_clk_en && step_count != '1)
      step_count <= step_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized self-checking bench for prog_load_ctrl against a transaction-level model.
module tb_prog_load_ctrl;
  localparam int OPCODE_W    = 21;
  localparam int ADDR_W      = 5;
  localparam int MAX_ENTRIES = 32;

  logic                clk = 1'b0;
  logic                reset, load_start, load_valid, load_last;
  logic [OPCODE_W-1:0] load_data;
  logic                load_ready, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [OPCODE_W-1:0] mem_wdata;
  logic [ADDR_W:0]     num_entries;
  logic                node_reset, node_clk_en;
  logic                run_cmd, halt_cmd, step_cmd;
  logic                running, load_err;
`ifdef PROG_LOAD_STEP_CNT_EN
  logic [15:0]         step_count;
`endif

  prog_load_ctrl #(.OPCODE_W(OPCODE_W), .ADDR_W(ADDR_W), .MAX_ENTRIES(MAX_ENTRIES)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .num_entries(num_entries), .node_reset(node_reset), .node_clk_en(node_clk_en),
    .run_cmd(run_cmd), .halt_cmd(halt_cmd), .step_cmd(step_cmd),
    .running(running), .load_err(load_err)
`ifdef PROG_LOAD_STEP_CNT_EN
    , .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // observed RAM writes and execute-enable cycles
  logic [ADDR_W+OPCODE_W-1:0] obs_wr[$];
  int clk_en_obs = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_wr.push_back({mem_addr, mem_wdata});
    if (node_clk_en === 1'b1) clk_en_obs++;
  end

  // reference model
  bit loaded  = 1'b0;
  int exp_ne  = 0;
  bit exp_err = 1'b0;
  int exp_clk = 0;
  int exp_sc  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds;
    load_start = 1'b0; run_cmd = 1'b0; halt_cmd = 1'b0; step_cmd = 1'b0;
  endtask

  task automatic check_quiescent(input string tag);
    check_val({tag, "_clken"}, node_clk_en, 0);
    check_val({tag, "_running"}, running, 0);
    check_val({tag, "_ready"}, load_ready, 0);
    check_val({tag, "_we"}, mem_we, 0);
    check_val({tag, "_nent"}, num_entries, exp_ne);
    check_val({tag, "_err"}, load_err, exp_err);
    check_val({tag, "_nreset"}, node_reset, !loaded);
    check_val({tag, "_clkcnt"}, clk_en_obs, exp_clk);
`ifdef PROG_LOAD_STEP_CNT_EN
    check_val({tag, "_stepcnt"}, step_count, exp_sc);
`endif
  endtask

  // last_idx < 0 or >= MAX_ENTRIES means no word carries load_last
  task automatic do_load(input bit with_halt, input int last_idx, input int gap_pct, input int abort_after);
    logic [OPCODE_W-1:0] words[$];
    int  exp_acc;
    bit  ovf;
    int  i;
    if (last_idx >= 0 && last_idx < MAX_ENTRIES) begin
      exp_acc = last_idx + 1; ovf = 1'b0;
    end else begin
      exp_acc = MAX_ENTRIES; ovf = 1'b1;
    end
    load_start = 1'b1; halt_cmd = with_halt;
    tick;
    clear_cmds;
    exp_sc = 0;
    check_val("ld_ready", load_ready, 1);
    check_val("ld_nreset", node_reset, 1);
    check_val("ld_clken", node_clk_en, 0);
    check_val("ld_err", load_err, 0);
    check_val("ld_nent_held", num_entries, exp_ne);
    obs_wr.delete();
    i = 0;
    while (i < exp_acc + (ovf ? 1 : 0)) begin
      if (abort_after >= 0 && i == abort_after) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        loaded = 1'b0; exp_ne = 0; exp_err = 1'b0; exp_sc = 0;
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_quiescent("rst_mid");
        obs_wr.delete();
        return;
      end
      if (i < exp_acc) begin
        load_start = ($urandom_range(0, 7) == 0);
        run_cmd    = ($urandom_range(0, 5) == 0);
        halt_cmd   = ($urandom_range(0, 5) == 0);
        step_cmd   = ($urandom_range(0, 5) == 0);
      end
      load_data = OPCODE_W'($urandom);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        load_valid = 1'b0;
        tick;
        clear_cmds;
        continue;
      end
      check_val("ld_ready_w", load_ready, i < exp_acc);
      load_valid = 1'b1;
      load_last  = (i == last_idx);
      if (i < exp_acc) words.push_back(load_data);
      tick;
      clear_cmds;
      load_valid = 1'b0; load_last = 1'b0;
      i++;
    end
    check_val("ld_ready_end", load_ready, 0);
    repeat (3) tick;
    loaded = 1'b1; exp_ne = exp_acc; exp_err = ovf;
    check_val("wr_count", obs_wr.size(), exp_acc);
    for (int j = 0; j < exp_acc && j < obs_wr.size(); j++)
      check_val("wr_word", obs_wr[j], {ADDR_W'(j), words[j]});
    check_quiescent("ld_done");
  endtask

  task automatic do_step;
    if (loaded) begin exp_clk += 1; exp_sc += 1; end
    step_cmd = 1'b1;
    tick;
    step_cmd = 1'b0;
    check_val("step_on", node_clk_en, loaded);
    tick;
    check_val("step_off", node_clk_en, 0);
    tick;
    check_quiescent("step");
  endtask

  // run for n execute cycles, then halt or (end_with_load) restart a load
  task automatic do_run(input int n, input bit end_with_load, input bit with_halt);
    run_cmd = 1'b1;
    tick;
    run_cmd = 1'b0;
    check_val("run_running", running, loaded);
    check_val("run_clken", node_clk_en, loaded);
    if (n > 1) repeat (n - 1) tick;
    if (loaded) begin exp_clk += n; exp_sc += n; end
    if (end_with_load) begin
      do_load(with_halt, $urandom_range(0, 40), $urandom_range(0, 40), -1);
    end else begin
      halt_cmd = 1'b1;
      tick;
      halt_cmd = 1'b0;
      check_val("halt_clken", node_clk_en, 0);
      check_val("halt_running", running, 0);
      tick;
      check_quiescent("run");
    end
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    clear_cmds;
    tick; tick;
    reset = 1'b0;
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_quiescent("reset");

    do_step;
    do_run(3, 1'b0, 1'b0);
    do_load(1'b0, 2, 0, -1);
    do_load(1'b0, 2, 50, -1);
    do_load(1'b0, -1, 0, -1);
    do_load(1'b0, 31, 10, -1);
    do_load(1'b0, 0, 0, -1);
    do_load(1'b0, 4, 0, -1);
    do_step;
    do_step;
    do_run(10, 1'b0, 1'b0);
    do_run(5, 1'b1, 1'b1);
    do_load(1'b0, 5, 20, 2);
    do_run(4, 1'b0, 1'b0);
    do_step;

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: do_load(1'b0, $urandom_range(0, 40), $urandom_range(0, 50), -1);
        1: do_step;
        2: do_run($urandom_range(1, 20), 1'b0, 1'b0);
        3: do_run($urandom_range(1, 20), 1'b1, $urandom_range(0, 1));
        4: do_load(1'b0, $urandom_range(3, 20), $urandom_range(0, 30), $urandom_range(0, 3));
        default: do_load($urandom_range(0, 1), $urandom_range(0, 10), 0, -1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Controller for one TIS node's program memory and execution. It accepts a stream of 21-bit opcodes over a valid/ready handshake and writes them into the node's 32-entry instruction RAM. It then reports the program length for the node's NUM_ENTRIES wrap/clamp logic and sequences the node's reset and clk_en for run, halt and single-step. One instance sits beside each node, between the host or debug interface and the node's instruction memory and PC.

Parameters:
OPCODE_W, 21, opcode word width
ADDR_W, 5, instruction RAM address width
MAX_ENTRIES, 32, RAM depth; must be ≤ 2**ADDR_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
load_start  in  1  pulse: begin new program load
load_valid  in  1  load_data valid
load_data  in  OPCODE_W  opcode word
load_last  in  1  qualifies final word of program
load_ready  out  1  controller accepts word this cycle
mem_we  out  1  instruction RAM write enable
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  OPCODE_W  RAM write data
num_entries  out  ADDR_W+1  program length, 1..MAX_ENTRIES (0 before any load)
node_reset  out  1  reset to node (PC, ACC, BAK)
node_clk_en  out  1  node execute enable
run_cmd  in  1  pulse: free-run
halt_cmd  in  1  pulse: stop
step_cmd  in  1  pulse: execute one instruction
running  out  1  state == RUN
load_err  out  1  sticky: overflow (no load_last by MAX_ENTRIES words)

Behaviour:
- All outputs registered. Commands sampled at a clk edge take effect on outputs the following cycle.
- Reset values:
  - state IDLE
  - load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - num_entries=0, node_reset=1, node_clk_en=0, running=0, load_err=0
- States: IDLE, LOAD, FLUSH, HALTED, RUN, STEP.
- IDLE:
  - node_reset=1.
  - load_start → LOAD.
  - run/halt/step ignored.
- LOAD:
  - node_reset=1, node_clk_en=0, load_ready=1.
  - Entry clears word counter cnt to 0 and clears load_err.
  - Word accepted when load_valid && load_ready. Next cycle: mem_we=1, mem_addr=cnt, mem_wdata=word. cnt increments.
  - mem_we is a single-cycle pulse per accepted word; there is no write when load_valid=0.
  - Accepted word with load_last=1 → FLUSH. load_ready=0 from the next cycle.
  - Accepted word MAX_ENTRIES without load_last → treated as last. load_err=1 → FLUSH.
  - load_start while in LOAD is ignored; loading continues.
  - run/halt/step are ignored in LOAD.
- FLUSH:
  - One cycle. node_reset=1. num_entries ← cnt (the final write is already issued). → HALTED.
  - A program must contain ≥1 word; load_last on the first word gives num_entries=1.
- HALTED:
  - node_reset=0, node_clk_en=0.
- RUN:
  - node_clk_en=1 every cycle, running=1.
  - halt_cmd → HALTED; node_clk_en=0 the cycle after halt_cmd is sampled.
- STEP:
  - node_clk_en=1 for exactly one cycle → HALTED.
  - Commands arriving during STEP: load_start is honoured; all others are ignored.
- Command priority in HALTED/RUN: load_start > halt_cmd > step_cmd > run_cmd.
  - run_cmd in RUN: no effect.
  - step_cmd in RUN: ignored.
  - halt_cmd in HALTED: no effect.
- load_start from HALTED/RUN/STEP → LOAD:
  - node_reset=1 and node_clk_en=0 from the next cycle.
  - The old num_entries is held until FLUSH.
- reset mid-load: everything returns to reset values immediately. RAM contents are undefined for the node; num_entries=0.

Optional Feature:
Macro PROG_LOAD_STEP_CNT_EN.
- Defined: adds output step_count[15:0]. It increments in every cycle node_clk_en=1, saturates at 16'hFFFF, and is cleared by reset and on entry to LOAD.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load 3 words A,B,C (last on C) with load_valid held → mem_we pulses at addr 0,1,2 with A,B,C on 3 consecutive cycles; num_entries=3; state HALTED; node_reset=0; load_err=0.
- Load with load_valid gaps (valid 1,0,0,1,1 with last on 3rd word) → exactly 3 writes, addr 0..2, no writes on gap cycles.
- Stream 33 words, none marked last, MAX_ENTRIES=32 → 32 writes; load_err=1; num_entries=32; load_ready=0 before word 33 is accepted.
- After load: step_cmd ×2 (separated) → node_clk_en exactly 2 single-cycle pulses. run_cmd, wait 10 cycles, halt_cmd → 10 clk_en cycles, then clk_en=0 the cycle after halt. With PROG_LOAD_STEP_CNT_EN: step_count=12.
- In RUN, load_start and halt_cmd in the same cycle → LOAD wins: node_reset=1, node_clk_en=0 next cycle, load_ready=1.
- reset asserted mid-load after 2 words → all outputs at reset values next cycle; num_entries=0; a subsequent run_cmd has no effect until a new load completes.
